// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output collector: FSM encoding, default
// feature-map geometry and the channel-index width helper.
package cnn_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam int DEF_CO = 3;
    localparam int DEF_OX = 24;
    localparam int DEF_OY = 24;

    function automatic int chan_w(input int co);
        return (co > 1) ? $clog2(co) : 1;
    endfunction

endpackage

// File: rtl/cnn_fmap_fifo.sv
// Synchronous first-word-fall-through FIFO for packed feature-map vectors.
// Pointers carry an extra wrap bit; a push into a full FIFO is ignored unless a pop frees the slot.
module cnn_fmap_fifo #(
    parameter int W     = 60,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cnn_fmap_collector.sv
// Buffers CO-channel output vectors and re-emits them one channel per beat.
// Define CNN_COLLECT_SAT_EN to saturate channel values instead of truncating.
module cnn_fmap_collector
    import cnn_pkg::*;
#(
    parameter int CO         = DEF_CO,
    parameter int O_F_BW     = 20,
    parameter int O_BW       = 8,
    parameter int OX         = DEF_OX,
    parameter int OY         = DEF_OY,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_in_valid,
    input  logic [CO*O_F_BW-1:0]   i_in_fmap,
    output logic                   o_ot_valid,
    input  logic                   i_ot_ready,
    output logic [O_BW-1:0]        o_ot_data,
    output logic [chan_w(CO)-1:0]  o_ot_chan,
    output logic                   o_ot_last,
    output logic                   o_overflow
);
    localparam int VW   = CO * O_F_BW;
    localparam int CW   = chan_w(CO);
    localparam int NPIX = OX * OY;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] CHAN_LAST = CW'(CO - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);

    state_e          state_q;
    logic [VW-1:0]   hold_q;
    logic [CW-1:0]   chan_q;
    logic [PW-1:0]   pix_q;
    logic            valid_q;
    logic [O_BW-1:0] data_q;
    logic            last_q;
    logic            ovf_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic [VW-1:0]   fifo_dout;
    logic            beat_done;
    logic            pop;
    logic [CW-1:0]   chan_inc;
    logic [PW-1:0]   pix_inc;

    function automatic logic [O_BW-1:0] narrow(input logic [VW-1:0] vec,
                                               input logic [CW-1:0] idx);
        logic [O_F_BW-1:0] v;
        v = vec[idx*O_F_BW +: O_F_BW];
`ifdef CNN_COLLECT_SAT_EN
        if (|v[O_F_BW-1:O_BW]) return '1;
`endif
        return v[O_BW-1:0];
    endfunction

    cnn_fmap_fifo #(
        .W     (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (i_in_valid),
        .pop   (pop),
        .din   (i_in_fmap),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // The hold register reloads either from IDLE or as the last channel is accepted.
    assign beat_done = (state_q == ST_SEND) && i_ot_ready && (chan_q == CHAN_LAST);
    assign pop       = !fifo_empty && ((state_q == ST_IDLE) || beat_done);
    assign chan_inc  = chan_q + CW'(1);
    assign pix_inc   = (pix_q == PIX_LAST) ? '0 : pix_q + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            chan_q  <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (i_in_valid && fifo_full && !pop) ovf_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        hold_q  <= fifo_dout;
                        chan_q  <= '0;
                        state_q <= ST_SEND;
                        valid_q <= 1'b1;
                        data_q  <= narrow(fifo_dout, '0);
                        last_q  <= (CO == 1) && (pix_q == PIX_LAST);
                    end
                end
                ST_SEND: begin
                    if (i_ot_ready) begin
                        if (chan_q != CHAN_LAST) begin
                            chan_q <= chan_inc;
                            data_q <= narrow(hold_q, chan_inc);
                            last_q <= (chan_inc == CHAN_LAST) && (pix_q == PIX_LAST);
                        end else begin
                            pix_q <= pix_inc;
                            if (pop) begin
                                hold_q <= fifo_dout;
                                chan_q <= '0;
                                data_q <= narrow(fifo_dout, '0);
                                last_q <= (CO == 1) && (pix_inc == PIX_LAST);
                            end else begin
                                state_q <= ST_IDLE;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ot_valid = valid_q;
    assign o_ot_data  = data_q;
    assign o_ot_chan  = chan_q;
    assign o_ot_last  = last_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_cnn_fmap_collector.sv
// Randomised and directed bench for cnn_fmap_collector against a queue-based
// reference model of the collector's buffering and beat sequencing.
module tb_cnn_fmap_collector;
    localparam int CO         = 3;
    localparam int O_F_BW     = 20;
    localparam int O_BW       = 8;
    localparam int OX         = 24;
    localparam int OY         = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int VW         = CO * O_F_BW;
    localparam int NPIX       = OX * OY;
`ifdef CNN_COLLECT_SAT_EN
    localparam int EXP300 = 255;
`else
    localparam int EXP300 = 44;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [VW-1:0]   in_fmap;
    logic            ot_ready;
    logic            o_ot_valid;
    logic [O_BW-1:0] o_ot_data;
    logic [1:0]      o_ot_chan;
    logic            o_ot_last;
    logic            o_overflow;

    always #5 clk = ~clk;

    cnn_fmap_collector #(
        .CO(CO), .O_F_BW(O_F_BW), .O_BW(O_BW), .OX(OX), .OY(OY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_in_valid (in_valid),
        .i_in_fmap  (in_fmap),
        .o_ot_valid (o_ot_valid),
        .i_ot_ready (ot_ready),
        .o_ot_data  (o_ot_data),
        .o_ot_chan  (o_ot_chan),
        .o_ot_last  (o_ot_last),
        .o_overflow (o_overflow)
    );

    // Reference model: vectors waiting, the vector being emitted, and frame position.
    logic [VW-1:0] m_q[$];
    logic [VW-1:0] m_vec;
    bit            m_busy;
    bit            m_ovf;
    int            m_chan;
    int            m_pix;

    int n_checks = 0;
    int n_errs   = 0;
    int hs_cnt   = 0;
    int last_cnt = 0;
    int last_idx = -1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chan_val(input logic [VW-1:0] vec, input int c);
        logic [VW-1:0] sh;
        sh = vec >> (c * O_F_BW);
        return int'(sh[O_F_BW-1:0]);
    endfunction

    function automatic int m_narrow(input int v);
`ifdef CNN_COLLECT_SAT_EN
        return (v > (1 << O_BW) - 1) ? (1 << O_BW) - 1 : v;
`else
        return v % (1 << O_BW);
`endif
    endfunction

    function automatic logic [VW-1:0] mk_vec(input int c2, input int c1, input int c0);
        logic [VW-1:0] v;
        v = '0;
        v[0*O_F_BW +: O_F_BW] = c0[O_F_BW-1:0];
        v[1*O_F_BW +: O_F_BW] = c1[O_F_BW-1:0];
        v[2*O_F_BW +: O_F_BW] = c2[O_F_BW-1:0];
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        int x;
        v = '0;
        for (int c = 0; c < CO; c++) begin
            x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 300))
                                            : int'($urandom_range(0, (1 << O_F_BW) - 1));
            v[c*O_F_BW +: O_F_BW] = x[O_F_BW-1:0];
        end
        return v;
    endfunction

    task automatic model_edge();
        bit pop;
        int sz;
        if (reset) begin
            m_q.delete();
            m_busy = 0;
            m_ovf  = 0;
            m_chan = 0;
            m_pix  = 0;
            return;
        end
        sz  = m_q.size();
        pop = 0;
        if (!m_busy) begin
            pop = (sz > 0);
        end else if (ot_ready) begin
            if (m_chan == CO - 1) begin
                m_pix  = (m_pix + 1) % NPIX;
                m_busy = 0;
                pop    = (sz > 0);
            end else begin
                m_chan++;
            end
        end
        if (pop) begin
            m_vec  = m_q.pop_front();
            m_chan = 0;
            m_busy = 1;
        end
        if (in_valid) begin
            if (sz < FIFO_DEPTH || pop) m_q.push_back(in_fmap);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_outputs();
        check("valid", o_ot_valid, m_busy);
        check("overflow", o_overflow, m_ovf);
        if (m_busy) begin
            check("data", o_ot_data, m_narrow(chan_val(m_vec, m_chan)));
            check("chan", o_ot_chan, m_chan);
            check("last", o_ot_last, (m_chan == CO - 1) && (m_pix == NPIX - 1));
        end else begin
            check("last_idle", o_ot_last, 0);
        end
    endtask

    // One clock: drive inputs, note the handshake, advance model, sample #1 after the edge.
    task automatic step(input bit v, input logic [VW-1:0] f, input bit r);
        in_valid = v;
        in_fmap  = f;
        ot_ready = r;
        if (!reset && o_ot_valid && r) begin
            if (o_ot_last) begin
                last_cnt++;
                last_idx = hs_cnt;
            end
            hs_cnt++;
        end
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, '0, 0);
        reset = 1'b0;
        check("rst_data", o_ot_data, 0);
        check("rst_chan", o_ot_chan, 0);
        check("rst_last", o_ot_last, 0);
        hs_cnt   = 0;
        last_cnt = 0;
        last_idx = -1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (m_busy || m_q.size() > 0); i++) step(0, '0, 1);
        step(0, '0, 1);
        check("drain_idle", o_ot_valid, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_fmap  = '0;
        ot_ready = 1'b0;
        #1;
        do_reset();

        // Single vector, latency and narrowing.
        step(1, mk_vec(5, 300, 7), 1);
        check("t1_not_yet", o_ot_valid, 0);
        step(0, '0, 1);
        check("t1_b0_data", o_ot_data, 7);
        check("t1_b0_chan", o_ot_chan, 0);
        step(0, '0, 1);
        check("t1_b1_data", o_ot_data, EXP300);
        check("t1_b1_chan", o_ot_chan, 1);
        step(0, '0, 1);
        check("t1_b2_data", o_ot_data, 5);
        check("t1_b2_chan", o_ot_chan, 2);
        step(0, '0, 1);
        check("t1_done", o_ot_valid, 0);

        // Stall mid-vector.
        step(1, mk_vec(11, 22, 33), 1);
        step(0, '0, 1);
        step(0, '0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 0);
            check("t2_hold_data", o_ot_data, 22);
            check("t2_hold_chan", o_ot_chan, 1);
        end
        step(0, '0, 1);
        check("t2_resume_data", o_ot_data, 11);
        drain();

        // Burst of six with the sink stalled: five held, sixth dropped.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, rand_vec(), 0);
            if (i == 4) check("t3_no_ovf_yet", o_overflow, 0);
        end
        check("t3_ovf", o_overflow, 1);
        step(0, '0, 0);
        drain();
        check("t3_beats", hs_cnt, 5 * CO);
        check("t3_ovf_sticky", o_overflow, 1);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, rand_vec(), 0);
        step(0, '0, 1);
        step(0, '0, 1);
        step(1, rand_vec(), 1);
        check("t4_no_ovf", o_overflow, 0);
        drain();
        check("t4_beats", hs_cnt, 6 * CO);

        // Reset in the middle of a vector.
        step(1, rand_vec(), 1);
        step(0, '0, 1);
        step(0, '0, 1);
        do_reset();
        check("t5_valid", o_ot_valid, 0);
        check("t5_ovf", o_overflow, 0);

        // One full frame paced every CO cycles, then the first beat of the next.
        for (int p = 0; p < NPIX; p++) begin
            step(1, rand_vec(), 1);
            for (int k = 1; k < CO; k++) step(0, '0, 1);
        end
        drain();
        check("t6_last_count", last_cnt, 1);
        check("t6_last_idx", last_idx, NPIX * CO - 1);
        check("t6_beats", hs_cnt, NPIX * CO);
        step(1, rand_vec(), 1);
        step(0, '0, 1);
        check("t6_wrap_chan", o_ot_chan, 0);
        check("t6_wrap_last", o_ot_last, 0);
        drain();

        // Random traffic and backpressure.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 99) < 40, rand_vec(), $urandom_range(0, 99) < 70);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/cnn_fmap_collector.md
# cnn_fmap_collector

Receiving end of the CNN core's output stream. Captures each packed CO-channel feature-map vector, buffers it in a small FIFO, and re-emits it one channel per beat on a valid/ready stream with channel index and end-of-frame marker. It sits between the convolution core and the downstream pooling/classifier stage, which can stall. The upstream core has no stall input, so the FIFO absorbs bursts and flags overflow.

## Interface
Parameters:
- CO, 3, channels per input vector
- O_F_BW, 20, width of one channel value in the input vector (unsigned, post-ReLU)
- O_BW, 8, width of one emitted channel value
- OX, 24, output feature-map width (IX-KX+1)
- OY, 24, output feature-map height
- FIFO_DEPTH, 4, vectors buffered; power of two, ≥2

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- i_in_valid  in  1  input vector valid; no backpressure to the source
- i_in_fmap  in  CO*O_F_BW  packed vector, channel c at [c*O_F_BW +: O_F_BW]
- o_ot_valid  out  1  output beat valid
- i_ot_ready  in  1  downstream accepts the beat
- o_ot_data  out  O_BW  channel value
- o_ot_chan  out  $clog2(CO)  channel index of the beat
- o_ot_last  out  1  last beat of the frame
- o_overflow  out  1  sticky; an input vector was dropped

## Operation
- Push: on i_in_valid with the FIFO not full, the vector is written. With the FIFO full, the vector is dropped, o_overflow is set, and it stays set until reset.
- FSM IDLE/SEND:
  - IDLE: if the FIFO is non-empty, pop the head into the hold register, set chan=0, and go to SEND.
  - SEND: o_ot_valid=1 and o_ot_data is the narrowed hold[chan]. On a handshake (valid&&ready):
    - chan<CO-1: increment chan.
    - chan==CO-1: increment the pixel counter. If the FIFO is non-empty, pop and reload the hold register in the same cycle, set chan=0, and stay in SEND. Otherwise go to IDLE.
- Pixel counter runs 0..OX*OY-1 and wraps to 0 after the last pixel.
- o_ot_last = o_ot_valid && chan==CO-1 && pixel==OX*OY-1.
- Simultaneous push and pop is legal when the FIFO is full: the pop frees the slot, so the push succeeds and there is no overflow.
- Narrowing width rule is in Configuration. Inputs are unsigned.
- Outputs are held stable while o_ot_valid=1 and i_ot_ready=0.

## Timing
- Reset values:
  - o_ot_valid=0, o_ot_data=0, o_ot_chan=0, o_ot_last=0, o_overflow=0
  - FIFO empty, pixel counter=0, FSM=IDLE
- Latency: a vector pushed at edge N into an empty FIFO with the FSM in IDLE is popped at N+1. Its first beat is valid after edge N+1, i.e. visible in cycle N+2.
- With i_ot_ready held at 1, the collector emits one beat per cycle, and back-to-back vectors produce no bubble between the last beat of one and the first beat of the next.
- Sustainable input rate without overflow is 1 vector per CO cycles. Bursts are absorbed up to FIFO_DEPTH.
- Reset asserted mid-frame or mid-vector aborts immediately: the FIFO is flushed, and the partial vector and frame position are discarded.

## Configuration
- CNN_COLLECT_SAT_EN defined: each channel value is saturated. Values above 2^O_BW-1 emit all-ones; others emit value[O_BW-1:0].
- Undefined: plain truncation, value[O_BW-1:0].

## Structure
- Shared package (cnn_pkg):
  - FSM state encoding (ST_IDLE, ST_SEND)
  - default OX/OY/CO constants
  - channel-index width function
- One sub-module, cnn_fmap_fifo: synchronous FIFO with width CO*O_F_BW and depth FIFO_DEPTH.
  - Pointers carry one extra wrap bit.
  - Ports: push, pop, full, empty, data in/out.
  - Push while full is ignored internally; the collector raises the flag.

## Test plan
- Single vector {c2=5, c1=300, c0=7}, ready=1 → beats 7, 300-sat, 5 at cycles N+2..N+4 with chan 0,1,2.
  - 300 emits 255 with SAT_EN defined and 44 without.
- Ready deasserted for 4 cycles mid-vector → data and chan hold steady; no beat is lost or duplicated.
- 6 back-to-back input vectors with ready=0 (FIFO_DEPTH=4) → 5 are held (4 in FIFO plus 1 in hold), the 6th is dropped, and o_overflow rises the cycle after it and stays high.
- Full frame OX*OY vectors paced every CO cycles with ready=1 → o_ot_last pulses exactly once, on beat OX*OY*CO-1. The next frame's first beat has chan=0 and the pixel counter has wrapped.
- FIFO full with push and pop in the same cycle → no overflow and the FIFO count is unchanged.
- Reset for one cycle mid-vector → all outputs return to reset values next cycle. A new vector then emits from chan 0, and o_ot_last timing restarts at pixel 0.
